// File: rtl/pc_pipe_pkg.sv
// Shared address/instruction width defines plus the stage-control type and decode
// used by the PC pipeline and its per-stage register.
`ifndef PC_PIPE_SHARED_DEFINES
`define PC_PIPE_SHARED_DEFINES
`define ADDRESS_LEN 32
`define INSTRUCTION_LEN 32
`endif

package pc_pipe_pkg;

  typedef enum logic [1:0] {
    STG_LOAD   = 2'd0,
    STG_HOLD   = 2'd1,
    STG_BUBBLE = 2'd2
  } stg_ctrl_e;

  // A taken branch wins over freeze; freeze holds reg 0 and bubbles only reg 1.
  function automatic stg_ctrl_e stage_ctrl(input int k, input int flush_depth,
                                           input logic branch, input logic freeze);
    stg_ctrl_e ctrl;
    ctrl = STG_LOAD;
    if (branch) begin
      if (k < flush_depth) ctrl = STG_BUBBLE;
    end else if (freeze) begin
      if (k == 0) ctrl = STG_HOLD;
      else if (k == 1) ctrl = STG_BUBBLE;
    end
    return ctrl;
  endfunction

endpackage

// File: rtl/pc_pipe_stage_reg.sv
// One inter-stage register carrying {valid, PC, instruction} with load/hold/bubble control.
module pipe_stage_reg
  import pc_pipe_pkg::*;
#(
  parameter int ADDR_W  = `ADDRESS_LEN,
  parameter int INSTR_W = `INSTRUCTION_LEN
) (
  input  logic               clk,
  input  logic               rst,
  input  stg_ctrl_e          ctrl,
  input  logic               d_valid,
  input  logic [ADDR_W-1:0]  d_pc,
  input  logic [INSTR_W-1:0] d_instr,
  output logic               q_valid,
  output logic [ADDR_W-1:0]  q_pc,
  output logic [INSTR_W-1:0] q_instr
);

  logic               valid_q, valid_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [INSTR_W-1:0] instr_q, instr_d;

  always_comb begin
    valid_d = valid_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    case (ctrl)
      STG_LOAD: begin
        valid_d = d_valid;
        pc_d    = d_pc;
        instr_d = d_instr;
      end
      STG_BUBBLE: begin
        valid_d = 1'b0;
        pc_d    = '0;
        instr_d = '0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      pc_q    <= '0;
      instr_q <= '0;
    end else begin
      valid_q <= valid_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
    end
  end

  assign q_valid = valid_q;
  assign q_pc    = pc_q;
  assign q_instr = instr_q;

endmodule

// File: rtl/pc_pipe.sv
// Fetch PC generator feeding a DEPTH-1 register pipeline with freeze/flush handling
// and retire/flush event counters.
module pc_pipe
  import pc_pipe_pkg::*;
#(
  parameter int ADDR_W      = `ADDRESS_LEN,
  parameter int INSTR_W     = `INSTRUCTION_LEN,
  parameter int DEPTH       = 5,
  parameter int FLUSH_DEPTH = 2,
  parameter int PC_STEP     = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           freeze,
  input  logic                           Branch_taken,
  input  logic [ADDR_W-1:0]              BranchAddr,
  input  logic [INSTR_W-1:0]             Instruction,
  output logic [ADDR_W-1:0]              PC_fetch,
  output logic [DEPTH-2:0]               stage_valid,
  output logic [(DEPTH-1)*ADDR_W-1:0]    stage_PC,
  output logic [(DEPTH-1)*INSTR_W-1:0]   stage_Instruction,
  output logic [31:0]                    retire_cnt,
  output logic [15:0]                    flush_cnt
);

  localparam int NREG = DEPTH - 1;

  logic [ADDR_W-1:0] pc_fetch_q, pc_fetch_d;
  logic [ADDR_W-1:0] pc_seq;
  logic [31:0]       retire_cnt_q, retire_cnt_d;
  logic [15:0]       flush_cnt_q, flush_cnt_d;

  assign pc_seq = pc_fetch_q + ADDR_W'(PC_STEP);

  always_comb begin
    pc_fetch_d   = pc_seq;
    retire_cnt_d = retire_cnt_q + {31'b0, stage_valid[NREG-1]};
    flush_cnt_d  = flush_cnt_q;
    if (Branch_taken) begin
      pc_fetch_d = BranchAddr;
      if (flush_cnt_q != 16'hFFFF) flush_cnt_d = flush_cnt_q + 16'd1;
    end else if (freeze) begin
      pc_fetch_d = pc_fetch_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_fetch_q   <= '0;
      retire_cnt_q <= '0;
      flush_cnt_q  <= '0;
    end else begin
      pc_fetch_q   <= pc_fetch_d;
      retire_cnt_q <= retire_cnt_d;
      flush_cnt_q  <= flush_cnt_d;
    end
  end

  for (genvar k = 0; k < NREG; k++) begin : g_stage
    stg_ctrl_e          ctrl;
    logic               in_valid;
    logic [ADDR_W-1:0]  in_pc;
    logic [INSTR_W-1:0] in_instr;

    assign ctrl = stage_ctrl(k, FLUSH_DEPTH, Branch_taken, freeze);

    // Reg 0 carries the sequential successor PC alongside the fetched word.
    if (k == 0) begin : g_head
      assign in_valid = 1'b1;
      assign in_pc    = pc_seq;
      assign in_instr = Instruction;
    end else begin : g_body
      assign in_valid = stage_valid[k-1];
      assign in_pc    = stage_PC[(k-1)*ADDR_W +: ADDR_W];
      assign in_instr = stage_Instruction[(k-1)*INSTR_W +: INSTR_W];
    end

    pipe_stage_reg #(
      .ADDR_W  (ADDR_W),
      .INSTR_W (INSTR_W)
    ) u_reg (
      .clk     (clk),
      .rst     (rst),
      .ctrl    (ctrl),
      .d_valid (in_valid),
      .d_pc    (in_pc),
      .d_instr (in_instr),
      .q_valid (stage_valid[k]),
      .q_pc    (stage_PC[k*ADDR_W +: ADDR_W]),
      .q_instr (stage_Instruction[k*INSTR_W +: INSTR_W])
    );
  end

  assign PC_fetch   = pc_fetch_q;
  assign retire_cnt = retire_cnt_q;
  assign flush_cnt  = flush_cnt_q;

endmodule

// File: tb/tb_pc_pipe.sv
// Bench for pc_pipe: a default instance (5 stages) and a 7-stage/3-flush instance
// driven by the same controls and checked against an array-based pipeline model.
module tb_pc_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, freeze, br;
  logic [31:0] baddr;

  logic [31:0]  pc_a, instr_a, ret_a;
  logic [3:0]   sv_a;
  logic [127:0] spc_a, sin_a;
  logic [15:0]  fl_a;

  logic [31:0]  pc_b, instr_b, ret_b;
  logic [5:0]   sv_b;
  logic [191:0] spc_b, sin_b;
  logic [15:0]  fl_b;

  int errors = 0;
  int checks = 0;

  function automatic logic [31:0] imem(input logic [31:0] pc);
    return {pc[15:0], ~pc[15:0]} ^ 32'h5A5A_0000;
  endfunction

  assign instr_a = imem(pc_a);
  assign instr_b = imem(pc_b);

  pc_pipe dut_a (
    .clk(clk), .rst(rst), .freeze(freeze), .Branch_taken(br), .BranchAddr(baddr),
    .Instruction(instr_a), .PC_fetch(pc_a), .stage_valid(sv_a), .stage_PC(spc_a),
    .stage_Instruction(sin_a), .retire_cnt(ret_a), .flush_cnt(fl_a)
  );

  pc_pipe #(.DEPTH(7), .FLUSH_DEPTH(3)) dut_b (
    .clk(clk), .rst(rst), .freeze(freeze), .Branch_taken(br), .BranchAddr(baddr),
    .Instruction(instr_b), .PC_fetch(pc_b), .stage_valid(sv_b), .stage_PC(spc_b),
    .stage_Instruction(sin_b), .retire_cnt(ret_b), .flush_cnt(fl_b)
  );

  // Reference model: index 0 = default instance, index 1 = 7-stage instance
  logic        m_v  [2][8];
  logic [31:0] m_pc [2][8];
  logic [31:0] m_in [2][8];
  logic [31:0] m_fetch [2];
  logic [31:0] m_ret [2];
  logic [15:0] m_fl [2];
  int          m_n  [2] = '{4, 6};
  int          m_fd [2] = '{2, 3};

  task automatic model_step(input int id);
    logic        nv [8];
    logic [31:0] np [8];
    logic [31:0] ni [8];
    for (int k = 0; k < 8; k++) begin
      nv[k] = 1'b0; np[k] = '0; ni[k] = '0;
    end
    for (int k = 0; k < m_n[id]; k++) begin
      if (br) begin
        if (k >= m_fd[id]) begin
          nv[k] = m_v[id][k-1]; np[k] = m_pc[id][k-1]; ni[k] = m_in[id][k-1];
        end
      end else if (freeze && k == 0) begin
        nv[k] = m_v[id][0]; np[k] = m_pc[id][0]; ni[k] = m_in[id][0];
      end else if (freeze && k == 1) begin
        nv[k] = 1'b0;
      end else if (k == 0) begin
        nv[k] = 1'b1; np[k] = m_fetch[id] + 32'd4; ni[k] = imem(m_fetch[id]);
      end else begin
        nv[k] = m_v[id][k-1]; np[k] = m_pc[id][k-1]; ni[k] = m_in[id][k-1];
      end
    end
    if (rst) begin
      m_ret[id] = '0; m_fl[id] = '0; m_fetch[id] = '0;
      for (int k = 0; k < 8; k++) begin
        nv[k] = 1'b0; np[k] = '0; ni[k] = '0;
      end
    end else begin
      m_ret[id] = m_ret[id] + (m_v[id][m_n[id]-1] ? 32'd1 : 32'd0);
      if (br && m_fl[id] != 16'hFFFF) m_fl[id] = m_fl[id] + 16'd1;
      if (br) m_fetch[id] = baddr;
      else if (!freeze) m_fetch[id] = m_fetch[id] + 32'd4;
    end
    for (int k = 0; k < 8; k++) begin
      m_v[id][k] = nv[k]; m_pc[id][k] = np[k]; m_in[id][k] = ni[k];
    end
  endtask

  task automatic step(input logic r, input logic f, input logic b, input logic [31:0] a);
    rst = r; freeze = f; br = b; baddr = a;
    @(posedge clk);
    model_step(0);
    model_step(1);
    #1;
  endtask

  task automatic test_reset();
    step(1, 0, 0, 0);
    step(1, 1, 1, 32'h40);
    checks++;
    if (pc_a !== 32'h0 || sv_a !== 4'h0 || spc_a !== '0 || sin_a !== '0) begin
      errors++;
      $display("FAIL reset_a_pipe: pc=%h valid=%b spc=%h sin=%h required all zero", pc_a, sv_a, spc_a, sin_a);
    end
    checks++;
    if (ret_a !== 32'h0 || fl_a !== 16'h0) begin
      errors++;
      $display("FAIL reset_a_cnt: retire=%0d flush=%0d required 0/0", ret_a, fl_a);
    end
    checks++;
    if (pc_b !== 32'h0 || sv_b !== 6'h0 || spc_b !== '0 || sin_b !== '0 || ret_b !== 0 || fl_b !== 0) begin
      errors++;
      $display("FAIL reset_b: pc=%h valid=%b required all zero", pc_b, sv_b);
    end
  endtask

  task automatic test_fill();
    step(1, 0, 0, 0);
    for (int i = 1; i <= 6; i++) begin
      step(0, 0, 0, 0);
      checks++;
      if (pc_a !== 32'(4 * i)) begin
        errors++;
        $display("FAIL fill_pc[%0d]: got %h required %h", i, pc_a, 32'(4 * i));
      end
      checks++;
      if (sv_a[3] !== (i >= 4)) begin
        errors++;
        $display("FAIL fill_valid3[%0d]: got %b required %b", i, sv_a[3], i >= 4);
      end
      if (i == 4) begin
        checks++;
        if (spc_a[127:96] !== 32'h4 || sin_a[127:96] !== imem(32'h0) || ret_a !== 0) begin
          errors++;
          $display("FAIL fill_reg3: pc=%h instr=%h retire=%0d required 4/%h/0", spc_a[127:96], sin_a[127:96], ret_a, imem(32'h0));
        end
      end
      if (i == 5) begin
        checks++;
        if (ret_a !== 32'd1) begin
          errors++;
          $display("FAIL fill_retire: got %0d required 1", ret_a);
        end
      end
      checks++;
      if (sv_b[5] !== (i >= 6)) begin
        errors++;
        $display("FAIL fill_b_latency[%0d]: valid5=%b required %b", i, sv_b[5], i >= 6);
      end
    end
    checks++;
    if (spc_b[191:160] !== 32'h4) begin
      errors++;
      $display("FAIL fill_b_reg5_pc: got %h required 4", spc_b[191:160]);
    end
  endtask

  task automatic test_freeze();
    logic [5:0] pat;
    step(1, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0);
    for (int i = 0; i < 2; i++) begin
      step(0, 1, 0, 32'h999);
      pat[i] = sv_a[3];
      checks++;
      if (pc_a !== 32'h10 || spc_a[31:0] !== 32'h10 || sin_a[31:0] !== imem(32'hC) || sv_a[0] !== 1'b1) begin
        errors++;
        $display("FAIL freeze_hold[%0d]: pc=%h reg0_pc=%h reg0_instr=%h required 10/10/%h", i, pc_a, spc_a[31:0], sin_a[31:0], imem(32'hC));
      end
      checks++;
      if (sv_a[1] !== 1'b0 || spc_a[63:32] !== 0 || sin_a[63:32] !== 0) begin
        errors++;
        $display("FAIL freeze_bubble1[%0d]: valid1=%b pc1=%h required bubble", i, sv_a[1], spc_a[63:32]);
      end
    end
    for (int i = 2; i < 6; i++) begin
      step(0, 0, 0, 0);
      pat[i] = sv_a[3];
    end
    checks++;
    if (pat !== 6'b110011) begin
      errors++;
      $display("FAIL freeze_gap: valid3 pattern %b required 110011", pat);
    end
  endtask

  task automatic test_branch();
    logic [3:0] pat_a;
    logic [5:0] pat_b;
    step(1, 0, 0, 0);
    for (int i = 0; i < 8; i++) step(0, 0, 0, 0);
    checks++;
    if (pc_a !== 32'h20) begin
      errors++;
      $display("FAIL branch_pre_pc: got %h required 20", pc_a);
    end
    step(0, 0, 1, 32'h100);
    checks++;
    if (pc_a !== 32'h100 || sv_a[1:0] !== 2'b00 || spc_a[63:0] !== 0 || fl_a !== 16'd1) begin
      errors++;
      $display("FAIL branch_flush: pc=%h valid=%b flush=%0d required 100/xx00/1", pc_a, sv_a, fl_a);
    end
    checks++;
    if (sv_b[2:0] !== 3'b000 || sv_b[5:3] !== 3'b111 || pc_b !== 32'h100) begin
      errors++;
      $display("FAIL branch_b_flush: valid=%b pc=%h required 111000/100", sv_b, pc_b);
    end
    for (int i = 0; i < 6; i++) begin
      step(0, 0, 0, 0);
      if (i < 4) pat_a[i] = sv_a[3];
      pat_b[i] = sv_b[5];
      if (i == 0) begin
        checks++;
        if (spc_a[31:0] !== 32'h104 || sin_a[31:0] !== imem(32'h100)) begin
          errors++;
          $display("FAIL branch_target: reg0 pc=%h instr=%h required 104/%h", spc_a[31:0], sin_a[31:0], imem(32'h100));
        end
      end
    end
    checks++;
    if (pat_a !== 4'b1001) begin
      errors++;
      $display("FAIL branch_bubbles_a: valid3 pattern %b required 1001", pat_a);
    end
    checks++;
    if (pat_b !== 6'b100011) begin
      errors++;
      $display("FAIL branch_bubbles_b: valid5 pattern %b required 100011", pat_b);
    end
  endtask

  task automatic test_freeze_branch();
    step(1, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0);
    step(0, 1, 1, 32'h200);
    checks++;
    if (pc_a !== 32'h200 || sv_a[1:0] !== 2'b00 || spc_a[31:0] !== 0 || sin_a[31:0] !== 0 || fl_a !== 16'd1) begin
      errors++;
      $display("FAIL freeze_branch: pc=%h valid=%b reg0_pc=%h flush=%0d required 200/xx00/0/1", pc_a, sv_a, spc_a[31:0], fl_a);
    end
    checks++;
    if (sv_a[2] !== 1'b1 || spc_a[95:64] !== 32'h8) begin
      errors++;
      $display("FAIL freeze_branch_adv: valid2=%b pc2=%h required 1/8", sv_a[2], spc_a[95:64]);
    end
    step(0, 0, 0, 0);
    checks++;
    if (pc_a !== 32'h204 || sv_a[0] !== 1'b1 || spc_a[31:0] !== 32'h204) begin
      errors++;
      $display("FAIL freeze_branch_resume: pc=%h reg0_pc=%h required 204/204", pc_a, spc_a[31:0]);
    end
  endtask

  task automatic test_rst_mid();
    step(1, 0, 0, 0);
    for (int i = 0; i < 8; i++) step(0, 0, 0, 0);
    step(0, 0, 1, 32'h80);
    for (int i = 0; i < 7; i++) step(0, 0, 0, 0);
    checks++;
    if (sv_a !== 4'hF || ret_a === 0 || fl_a !== 16'd1) begin
      errors++;
      $display("FAIL rst_mid_pre: valid=%b retire=%0d flush=%0d required full/nonzero/1", sv_a, ret_a, fl_a);
    end
    step(1, 1, 1, 32'h300);
    checks++;
    if (pc_a !== 0 || sv_a !== 0 || spc_a !== 0 || sin_a !== 0 || ret_a !== 0 || fl_a !== 0) begin
      errors++;
      $display("FAIL rst_mid: pc=%h valid=%b retire=%0d flush=%0d required all zero", pc_a, sv_a, ret_a, fl_a);
    end
    step(0, 0, 0, 0);
    checks++;
    if (pc_a !== 32'h4 || sv_a !== 4'b0001 || spc_a[31:0] !== 32'h4) begin
      errors++;
      $display("FAIL rst_mid_restart: pc=%h valid=%b required 4/0001", pc_a, sv_a);
    end
  endtask

  task automatic test_random();
    logic r, f, b;
    step(1, 0, 0, 0);
    for (int c = 0; c < 500; c++) begin
      r = ($urandom_range(0, 79) == 0);
      f = ($urandom_range(0, 3) == 0);
      b = ($urandom_range(0, 6) == 0);
      step(r, f, b, $urandom & 32'hFFFF_FFFC);
      checks++;
      if (pc_a !== m_fetch[0] || ret_a !== m_ret[0] || fl_a !== m_fl[0]) begin
        errors++;
        $display("FAIL rand_a_top[%0d]: pc=%h ret=%0d fl=%0d required %h/%0d/%0d", c, pc_a, ret_a, fl_a, m_fetch[0], m_ret[0], m_fl[0]);
      end
      checks++;
      if (pc_b !== m_fetch[1] || ret_b !== m_ret[1] || fl_b !== m_fl[1]) begin
        errors++;
        $display("FAIL rand_b_top[%0d]: pc=%h ret=%0d fl=%0d required %h/%0d/%0d", c, pc_b, ret_b, fl_b, m_fetch[1], m_ret[1], m_fl[1]);
      end
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (sv_a[k] !== m_v[0][k] || spc_a[k*32 +: 32] !== m_pc[0][k] || sin_a[k*32 +: 32] !== m_in[0][k]) begin
          errors++;
          $display("FAIL rand_a_reg%0d[%0d]: v=%b pc=%h in=%h required %b/%h/%h", k, c, sv_a[k], spc_a[k*32 +: 32], sin_a[k*32 +: 32], m_v[0][k], m_pc[0][k], m_in[0][k]);
        end
      end
      for (int k = 0; k < 6; k++) begin
        checks++;
        if (sv_b[k] !== m_v[1][k] || spc_b[k*32 +: 32] !== m_pc[1][k] || sin_b[k*32 +: 32] !== m_in[1][k]) begin
          errors++;
          $display("FAIL rand_b_reg%0d[%0d]: v=%b pc=%h in=%h required %b/%h/%h", k, c, sv_b[k], spc_b[k*32 +: 32], sin_b[k*32 +: 32], m_v[1][k], m_pc[1][k], m_in[1][k]);
        end
      end
    end
  endtask

  task automatic test_flush_sat();
    step(1, 0, 0, 0);
    for (int i = 1; i <= 65540; i++) begin
      step(0, i[0], 1, 32'h1000);
      if (i == 65534 || i == 65535 || i == 65540) begin
        checks++;
        if (fl_a !== ((i == 65534) ? 16'hFFFE : 16'hFFFF)) begin
          errors++;
          $display("FAIL flush_sat[%0d]: got %h required %h", i, fl_a, (i == 65534) ? 16'hFFFE : 16'hFFFF);
        end
      end
    end
    checks++;
    if (fl_b !== 16'hFFFF || pc_a !== 32'h1000) begin
      errors++;
      $display("FAIL flush_sat_b: flush_b=%h pc=%h required FFFF/1000", fl_b, pc_a);
    end
  endtask

  initial begin
    rst = 1'b1; freeze = 1'b0; br = 1'b0; baddr = '0;
    for (int id = 0; id < 2; id++) begin
      m_fetch[id] = '0; m_ret[id] = '0; m_fl[id] = '0;
      for (int k = 0; k < 8; k++) begin
        m_v[id][k] = 1'b0; m_pc[id][k] = '0; m_in[id][k] = '0;
      end
    end
    #1;
    test_reset();
    test_fill();
    test_freeze();
    test_branch();
    test_freeze_branch();
    test_rst_mid();
    test_random();
    test_flush_sat();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
